// File: rtl/regfile_mp.sv
// Multi-port integer register file: two combinational read ports, dual retire
// write ports, per-register pending scoreboard, and a post-reset clear sweep.
module regfile_mp #(
   parameter int XLEN   = 32,
   parameter int AW     = 5,
   parameter int BYPASS = 1,
   parameter int DBG_AW = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AW-1:0]     rs1_addr,
   input  logic [AW-1:0]     rs2_addr,
   output logic [XLEN-1:0]   rs1_data,
   output logic [XLEN-1:0]   rs2_data,
   output logic              rs1_busy,
   output logic              rs2_busy,
   input  logic              we0,
   input  logic              we1,
   input  logic [AW-1:0]     wa0,
   input  logic [AW-1:0]     wa1,
   input  logic [XLEN-1:0]   wd0,
   input  logic [XLEN-1:0]   wd1,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_rd,
   input  logic [DBG_AW-1:0] debug_addr,
   output logic [XLEN-1:0]   debug_data,
   output logic              init_done
);

   localparam int NREG = 1 << AW;

   logic [XLEN-1:0] mem_q [NREG];
   logic [NREG-1:0] pending_q, pending_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic            initDone_q, initDone_d;

   logic wq0, wq1, issQual, dbgOutOfRange;

   // A write or issue only counts once the sweep is finished and reset is not
   // being applied at this edge; entry 0 is never a real destination.
   assign wq0     = rst_n && initDone_q && we0 && (wa0 != '0);
   assign wq1     = rst_n && initDone_q && we1 && (wa1 != '0);
   assign issQual = rst_n && initDone_q && iss_valid && (iss_rd != '0);

   assign init_done = initDone_q;

   // Array has no reset so it can map onto distributed RAM; the sweep clears it.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (!initDone_q) begin
            mem_q[cnt_q] <= '0;
         end else begin
            if (wq0 && !(wq1 && (wa1 == wa0))) begin
               mem_q[wa0] <= wd0;
            end
            if (wq1) begin
               mem_q[wa1] <= wd1;
            end
         end
      end
   end

   always_comb begin
      cnt_d      = cnt_q;
      initDone_d = initDone_q;
      if (!initDone_q) begin
         if (cnt_q == AW'(NREG - 1)) begin
            initDone_d = 1'b1;
         end else begin
            cnt_d = cnt_q + AW'(1);
         end
      end
   end

   // Issue sets after retire clears so a same-address collision stays pending.
   always_comb begin
      pending_d = pending_q;
      if (wq0) begin
         pending_d[wa0] = 1'b0;
      end
      if (wq1) begin
         pending_d[wa1] = 1'b0;
      end
      if (issQual) begin
         pending_d[iss_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_q  <= '0;
         cnt_q      <= AW'(1);
         initDone_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         cnt_q      <= cnt_d;
         initDone_q <= initDone_d;
      end
   end

   function automatic logic [XLEN:0] readPort(input logic [AW-1:0] a);
      logic [XLEN:0] r;
      r = '0;
      if (initDone_q && (a != '0)) begin
         if ((BYPASS != 0) && wq1 && (wa1 == a)) begin
            r = {1'b0, wd1};
         end else if ((BYPASS != 0) && wq0 && (wa0 == a)) begin
            r = {1'b0, wd0};
         end else begin
            r = {pending_q[a], mem_q[a]};
         end
      end
      return r;
   endfunction

   always_comb begin
      {rs1_busy, rs1_data} = readPort(rs1_addr);
      {rs2_busy, rs2_data} = readPort(rs2_addr);
   end

   generate
      if (DBG_AW > AW) begin : gDbgWide
         assign dbgOutOfRange = |debug_addr[DBG_AW-1:AW];
      end else begin : gDbgNarrow
         assign dbgOutOfRange = 1'b0;
      end
   endgenerate

   always_comb begin
      debug_data = '0;
      if (initDone_q && !dbgOutOfRange && (debug_addr[AW-1:0] != '0)) begin
         debug_data = mem_q[debug_addr[AW-1:0]];
      end
   end

endmodule
